// File: rtl/sprite_line_scheduler.sv
// rtl/sprite_line_scheduler.sv - per-scanline sprite scheduler and attribute RAM arbiter
module sprite_line_scheduler #(
    parameter int MAX_SPRITES = 8,
    parameter int SLOTS       = 4,
    parameter int IDX_W       = 3,
    parameter int SPRITE_H    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   line_start,
    input  logic [9:0]             next_y,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [IDX_W-1:0]       cpu_addr,
    input  logic [15:0]            cpu_wdata,
    output logic [15:0]            cpu_rdata,
    output logic                   cpu_ready,
    output logic [IDX_W-1:0]       ram_addr,
    output logic                   ram_we,
    output logic [15:0]            ram_wdata,
    input  logic [15:0]            ram_rdata,
    output logic [SLOTS-1:0]       slot_valid,
    output logic [SLOTS*IDX_W-1:0] slot_idx,
    output logic                   sched_done,
    output logic                   overflow,
    output logic                   busy
);
    localparam int CNT_W = $clog2(SLOTS + 1);

    typedef enum logic [2:0] {IDLE, CPU, SCAN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [IDX_W-1:0]       ptr;
    logic [9:0]             y_lat;
    logic                   pend_line;
    logic [SLOTS-1:0]       sh_valid, nxt_valid;
    logic [SLOTS*IDX_W-1:0] sh_idx, nxt_idx;
    logic [CNT_W-1:0]       sh_cnt, nxt_cnt;
    logic                   sh_ovf, nxt_ovf;
    logic                   accept, eval, hit;
    logic [IDX_W-1:0]       eval_idx;
    logic [9:0]             dy;

    assign accept = (state == IDLE) && (line_start || pend_line);

    // RAM data lags the address by one cycle, so the entry being judged is ptr-1;
    // in DRAIN ptr has already moved past the last entry.
    assign eval     = ((state == SCAN) && (ptr != '0)) || (state == DRAIN);
    assign eval_idx = ptr - IDX_W'(1);
    assign dy       = y_lat - ram_rdata[9:0];
    assign hit      = eval && ram_rdata[15] && ({1'b0, dy} < 11'(SPRITE_H));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        ram_addr   = '0;
        ram_we     = 1'b0;
        ram_wdata  = '0;
        cpu_ready  = 1'b0;
        cpu_rdata  = '0;
        busy       = 1'b0;
        sched_done = 1'b0;
        case (state)
            IDLE: begin
                if (line_start || pend_line) begin
                    state_nxt = SCAN;
                end else if (cpu_req) begin
                    ram_addr  = cpu_addr;
                    ram_we    = cpu_we;
                    ram_wdata = cpu_wdata;
                    state_nxt = CPU;
                end
            end
            CPU: begin
                cpu_ready = 1'b1;
                if (!cpu_we) cpu_rdata = ram_rdata;
                state_nxt = IDLE;
            end
            SCAN: begin
                ram_addr = ptr;
                busy     = 1'b1;
                if (ptr == IDX_W'(MAX_SPRITES - 1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                sched_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Hits fill the next free slot in scan order; extras only raise overflow.
    always_comb begin
        nxt_valid = sh_valid;
        nxt_idx   = sh_idx;
        nxt_cnt   = sh_cnt;
        nxt_ovf   = sh_ovf;
        if (hit) begin
            if (sh_cnt < CNT_W'(SLOTS)) begin
                for (int k = 0; k < SLOTS; k++) begin
                    if (sh_cnt == CNT_W'(k)) begin
                        nxt_valid[k]             = 1'b1;
                        nxt_idx[k*IDX_W +: IDX_W] = eval_idx;
                    end
                end
                nxt_cnt = sh_cnt + CNT_W'(1);
            end else begin
                nxt_ovf = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr        <= '0;
            y_lat      <= '0;
            pend_line  <= 1'b0;
            sh_valid   <= '0;
            sh_idx     <= '0;
            sh_cnt     <= '0;
            sh_ovf     <= 1'b0;
            slot_valid <= '0;
            slot_idx   <= '0;
            overflow   <= 1'b0;
        end else if (accept) begin
            y_lat     <= next_y;
            ptr       <= '0;
            pend_line <= 1'b0;
            sh_valid  <= '0;
            sh_idx    <= '0;
            sh_cnt    <= '0;
            sh_ovf    <= 1'b0;
        end else begin
            if ((state == CPU) && line_start) pend_line <= 1'b1;
            if (state == SCAN) ptr <= ptr + IDX_W'(1);
            sh_valid <= nxt_valid;
            sh_idx   <= nxt_idx;
            sh_cnt   <= nxt_cnt;
            sh_ovf   <= nxt_ovf;
            // Publish at the end of DRAIN so the new slots appear with sched_done.
            if (state == DRAIN) begin
                slot_valid <= nxt_valid;
                slot_idx   <= nxt_idx;
                overflow   <= nxt_ovf;
            end
        end
    end
endmodule
